// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int ARB_N_DEFAULT        = 4;
  localparam int ARB_MAX_HOLD_DEFAULT = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: the search starts one past last_id and wraps; the first set req bit wins.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N    = ARB_N_DEFAULT,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_id,
  output logic            any_req,
  output logic [ID_W-1:0] win_id
);

  logic found;

  always_comb begin
    any_req = |req;
    win_id  = '0;
    found   = 1'b0;
    // k = N wraps back to last_id itself, so a lone requester can win again
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last_id) + k) % N]) begin
        win_id = ID_W'((int'(last_id) + k) % N);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a bounded grant length, a one-cycle gap after each grant,
// and registered outputs. state_dbg exposes the FSM state register.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = ARB_N_DEFAULT,
  parameter  int MAX_HOLD = ARB_MAX_HOLD_DEFAULT,
  localparam int ID_W     = $clog2(N),
  localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            timeout,
  output arb_state_e      state_dbg
);

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  // Handshake: an owner keeps gnt until it pulses done or drops its own req bit;
  // otherwise the grant is revoked after MAX_HOLD cycles with a one-cycle timeout pulse.

  arb_state_e       state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;

  logic             any_req;
  logic [ID_W-1:0]  win_id;
  logic             rel_evt;

  rr_pick #(.N(N)) u_pick (
    .req     (req),
    .last_id (last_id_q),
    .any_req (any_req),
    .win_id  (win_id)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    last_id_d  = last_id_q;
    rel_evt    = done || !req[gnt_id_q];

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = GRANT;
          gnt_d      = ONE_HOT0 << win_id;
          gnt_id_d   = win_id;
          busy_d     = 1'b1;
          hold_cnt_d = CNT_W'(1);
          last_id_d  = win_id;
        end
      end
      GRANT: begin
        // A release in the limit cycle takes priority, so no timeout is flagged then
        if (rel_evt || (hold_cnt_q == CNT_W'(MAX_HOLD))) begin
          state_d    = GAP;
          gnt_d      = '0;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
          timeout_d  = !rel_evt;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
      last_id_q  <= ID_W'(N - 1);
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      last_id_q  <= last_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
  assign state_dbg = state_q;

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter MAX_HOLD, default 8, maximum grant length in cycles (>=2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  N  per-requester request level; bit i = requester i.
REQ-006 done  input  1  owner's release pulse; sampled only while a grant is active.
REQ-007 gnt  output  N  one-hot grant, registered; all-zero when no owner.
REQ-008 gnt_id  output  $clog2(N)  index of the current owner, valid only while busy=1.
REQ-009 busy  output  1  registered; high exactly when gnt is non-zero.
REQ-010 timeout  output  1  registered one-cycle pulse when a grant is revoked at MAX_HOLD.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT and GAP.
REQ-012 IDLE: if any req bit is 1 at a posedge, the SHALL-state moves to GRANT at that edge, and gnt, gnt_id and busy become valid from that edge (1-cycle request-to-grant latency).
REQ-013 Winner selection SHALL be round-robin: search starts at last_id+1 mod N, and the first set req bit wins.
REQ-014 last_id SHALL update to the winner at the edge where the grant is issued.
REQ-015 GRANT: hold_cnt SHALL load 1 at grant issue and increment each cycle the grant is held.
REQ-016 GRANT -> GAP when done=1, or when req[gnt_id]=0 (treated as release); no timeout pulse.
REQ-017 GRANT -> GAP when hold_cnt=MAX_HOLD without release; timeout=1 for exactly the one cycle following that edge.
REQ-018 If a release and hold_cnt=MAX_HOLD occur in the same cycle, release SHALL win and timeout SHALL stay 0.
REQ-019 At GRANT exit, gnt SHALL go all-zero and busy SHALL go 0 at the same edge.
REQ-020 GAP SHALL last exactly one cycle with no owner, then go to IDLE.
REQ-021 The minimum spacing between two grants SHALL therefore be one idle cycle (GAP) plus the IDLE arbitration cycle.
REQ-022 done SHALL be ignored in IDLE and GAP.
REQ-023 req changes during GRANT SHALL not affect the owner, except for the owner's own bit (REQ-016).
REQ-024 gnt SHALL never have more than one bit set.
REQ-025 busy SHALL always equal |gnt.
REQ-026 hold_cnt SHALL be $clog2(MAX_HOLD+1) bits wide and never wrap.

Reset
REQ-027 On rst=1 at a posedge: state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, hold_cnt=0.
REQ-028 On reset, last_id SHALL be set to N-1, so requester 0 has first priority.
REQ-029 Reset asserted mid-grant SHALL drop gnt at that edge, with no timeout pulse.
REQ-030 Reset SHALL take precedence over all other inputs.

Structure
REQ-031 Package arb_pkg SHALL hold the state enum (IDLE, GRANT, GAP) and the default constants for N and MAX_HOLD.
REQ-032 One combinational sub-module, rr_pick, SHALL implement the rotate-priority encoder.
REQ-033 rr_pick inputs: req, last_id. Outputs: any_req, win_id.
REQ-034 All outputs of rr_arbiter SHALL be driven directly from flops.

Verification
REQ-035 Scenario (reset priority): after reset, req=4'b1111 -> gnt=4'b0001 one cycle later; done after 2 cycles -> then gnt=4'b0010.
REQ-036 Scenario (rotation): req held at 4'b1111 with done after every grant -> gnt sequence 0001, 0010, 0100, 1000, 0001, with a 2-cycle gap between grants.
REQ-037 Scenario (timeout): req=4'b0100 held, done never -> gnt=4'b0100 for exactly 8 cycles, then timeout=1 for 1 cycle, then the grant re-issues to requester 2 after the gap.
REQ-038 Scenario (simultaneous release and limit): done=1 in the 8th held cycle -> timeout stays 0, and the GAP follows.
REQ-039 Scenario (owner drops request): gnt=4'b0010, then req[1] deasserted -> gnt=0 at the next edge, no timeout.
REQ-040 Scenario (reset mid-grant): rst pulsed during gnt=4'b1000 -> all outputs 0 at that edge; then req=4'b1001 -> gnt=4'b0001.
REQ-041 Assertions SHALL check, on every cycle, that gnt is one-hot-or-zero, that busy==|gnt, and that timeout lasts exactly one cycle.
